// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter sharing one RAM port between the instruction and data
// request ports of CPUS cores, with a locked grant and a per-transaction watchdog.
module ram_rr_arbiter #(
    parameter int CPUS    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [CPUS-1:0]     iREN,
    input  logic [CPUS-1:0]     dREN,
    input  logic [CPUS-1:0]     dWEN,
    input  logic [32*CPUS-1:0]  iaddr,
    input  logic [32*CPUS-1:0]  daddr,
    input  logic [32*CPUS-1:0]  dstore,
    output logic [CPUS-1:0]     iwait,
    output logic [CPUS-1:0]     dwait,
    output logic [32*CPUS-1:0]  iload,
    output logic [32*CPUS-1:0]  dload,
    input  logic [1:0]          ramstate,
    input  logic [31:0]         ramload,
    output logic                ramREN,
    output logic                ramWEN,
    output logic [31:0]         ramaddr,
    output logic [31:0]         ramstore,
    output logic [1:0]          gnt_cpu,
    output logic                timeout_err
);

    localparam int IW = (CPUS > 2) ? 2 : 1;
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_I    = 2'd1,
        SRC_DR   = 2'd2,
        SRC_DW   = 2'd3
    } src_e;

    state_e          state_q, state_d;
    src_e            gnt_src_q, gnt_src_d;
    logic [IW-1:0]   gnt_cpu_q, gnt_cpu_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [31:0]     iaddr_a  [CPUS];
    logic [31:0]     daddr_a  [CPUS];
    logic [31:0]     dstore_a [CPUS];

    logic [CPUS-1:0] core_req_s;
    logic [IW-1:0]   win_s;
    logic [IW-1:0]   cand_s;
    logic            found_s;
    src_e            win_src_s;
    logic            gnt_req_s;
    logic            at_limit_s;
    logic            xfer_live_s;
    logic            drop_s;
    logic            drop_i_s;
    logic            drop_d_s;

    for (genvar g = 0; g < CPUS; g++) begin : g_unpack
        assign iaddr_a[g]  = iaddr[32*g +: 32];
        assign daddr_a[g]  = daddr[32*g +: 32];
        assign dstore_a[g] = dstore[32*g +: 32];
    end

    assign core_req_s = iREN | dREN | dWEN;
    assign at_limit_s = (cnt_q == CW'(TIMEOUT - 1));

    // Round-robin scan: first requesting core at or after rr_ptr (index wraps naturally).
    always_comb begin
        win_s   = '0;
        found_s = 1'b0;
        cand_s  = '0;
        for (int i = 0; i < CPUS; i++) begin
            cand_s = rr_ptr_q + IW'(i);
            if (!found_s && core_req_s[cand_s]) begin
                win_s   = cand_s;
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Fixed source priority inside the winning core; dWEN with dREN counts as a write.
    always_comb begin
        if (dWEN[win_s]) begin
            win_src_s = SRC_DW;
        end else if (dREN[win_s]) begin
            win_src_s = SRC_DR;
        end else if (iREN[win_s]) begin
            win_src_s = SRC_I;
        end else begin
            win_src_s = SRC_NONE;
        end
    end

    // Is the request bit behind the current grant still asserted?
    always_comb begin
        case (gnt_src_q)
            SRC_I:   gnt_req_s = iREN[gnt_cpu_q];
            SRC_DR:  gnt_req_s = dREN[gnt_cpu_q];
            SRC_DW:  gnt_req_s = dWEN[gnt_cpu_q];
            default: gnt_req_s = 1'b0;
        endcase
    end

    // State and grant registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            gnt_src_q <= SRC_NONE;
            gnt_cpu_q <= '0;
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_src_q <= gnt_src_d;
            gnt_cpu_q <= gnt_cpu_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state logic; rr_ptr only moves after a completed or aborted transfer.
    always_comb begin
        state_d   = state_q;
        gnt_src_d = gnt_src_q;
        gnt_cpu_d = gnt_cpu_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|core_req_s) begin
                    gnt_cpu_d = win_s;
                    gnt_src_d = win_src_s;
                    cnt_d     = '0;
                    state_d   = ST_XFER;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (!gnt_req_s) begin
                    gnt_src_d = SRC_NONE;
                    state_d   = ST_IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    state_d   = ST_DONE;
                end else if (at_limit_s) begin
                    state_d   = ST_DONE;
                end else begin
                    cnt_d     = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                rr_ptr_d  = gnt_cpu_q + IW'(1);
                gnt_src_d = SRC_NONE;
                state_d   = ST_IDLE;
            end
            default: begin
                gnt_src_d = SRC_NONE;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // RST masks every output so a transfer caught by reset never completes.
    assign xfer_live_s = !RST && (state_q == ST_XFER) && gnt_req_s;

    // RAM-side outputs and completion/abort strobes.
    always_comb begin
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = 32'd0;
        ramstore    = 32'd0;
        drop_s      = 1'b0;
        timeout_err = 1'b0;
        if (xfer_live_s) begin
            case (gnt_src_q)
                SRC_I: begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr_a[gnt_cpu_q];
                end
                SRC_DR: begin
                    ramREN  = 1'b1;
                    ramaddr = daddr_a[gnt_cpu_q];
                end
                SRC_DW: begin
                    ramWEN   = 1'b1;
                    ramaddr  = daddr_a[gnt_cpu_q];
                    ramstore = dstore_a[gnt_cpu_q];
                end
                default: begin
                    ramREN = 1'b0;
                end
            endcase
            if (ramstate == RAM_ACCESS) begin
                drop_s = 1'b1;
            end else if (at_limit_s) begin
                timeout_err = 1'b1;
            end else begin
                drop_s = 1'b0;
            end
        end else begin
            drop_s = 1'b0;
        end
    end

    assign drop_i_s = drop_s && (gnt_src_q == SRC_I);
    assign drop_d_s = drop_s && ((gnt_src_q == SRC_DR) || (gnt_src_q == SRC_DW));

    for (genvar g = 0; g < CPUS; g++) begin : g_lane
        assign iwait[g]          = ~(drop_i_s && (gnt_cpu_q == IW'(g)));
        assign dwait[g]          = ~(drop_d_s && (gnt_cpu_q == IW'(g)));
        assign iload[32*g +: 32] = (drop_i_s && (gnt_cpu_q == IW'(g))) ? ramload : 32'd0;
        assign dload[32*g +: 32] = (drop_d_s && (gnt_cpu_q == IW'(g))) ? ramload : 32'd0;
    end

    assign gnt_cpu = 2'(gnt_cpu_q);

endmodule

// File: doc/ram_rr_arbiter.md
Name: ram_rr_arbiter

Overview:
- Registered, round-robin arbiter that shares the single RAM port between CPUS cores, each with one instruction request port and one data request port.
- Sits between the per-core cache request signals and the RAM model. Replaces purely combinational priority muxing with a granted, locked transaction.
- Adds fairness across cores and a timeout watchdog.

Parameters:
- CPUS, 2, number of cores; supported values are 2 and 4.
- TIMEOUT, 64, number of cycles a granted transaction may wait for ACCESS before it is aborted; minimum 2.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- iREN  in  CPUS  instruction read request, one bit per core.
- dREN  in  CPUS  data read request, one bit per core.
- dWEN  in  CPUS  data write request, one bit per core.
- iaddr  in  32*CPUS  instruction address; core k occupies bits [32k+31:32k].
- daddr  in  32*CPUS  data address; same packing as iaddr.
- dstore  in  32*CPUS  data write value; same packing as iaddr.
- iwait  out  CPUS  instruction wait, active high.
- dwait  out  CPUS  data wait, active high.
- iload  out  32*CPUS  instruction read data.
- dload  out  32*CPUS  data read data.
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- ramload  in  32  RAM read data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- gnt_cpu  out  2  index of the core currently granted.
- timeout_err  out  1  one-cycle pulse when a transaction is aborted by the watchdog.

Behaviour:
- Reset: synchronous, applied while RST=1.
  - FSM goes to IDLE; rr_ptr=0; gnt_cpu=0; gnt_src=NONE; timeout counter=0.
  - All iwait/dwait bits read 1; ramREN=ramWEN=0; ramaddr=ramstore=0; iload=dload=0; timeout_err=0.
  - RST asserted mid-transaction abandons the transaction; no wait bit drops low in that cycle.
- Core selection, evaluated in IDLE:
  - A core is requesting if any of its iREN, dREN or dWEN bits is set.
  - The winner is the first requesting core found scanning from rr_ptr upward, modulo CPUS.
- Source selection within the winning core, fixed priority: dWEN, then dREN, then iREN.
  - dWEN and dREN together is treated as a write.
- FSM states: IDLE, XFER, DONE.
- IDLE:
  - If any core is requesting, register gnt_cpu and gnt_src (I, DR or DW), clear the timeout counter, go to XFER.
  - Otherwise stay in IDLE; RAM outputs are all zero.
- XFER:
  - ramaddr/ramstore/ramREN/ramWEN are driven combinationally from the registered grant and the current request inputs.
  - If the granted request bit deasserts, drive nothing to RAM and return to IDLE; rr_ptr is not advanced.
  - If ramstate==ACCESS:
    - Drop the granted wait bit to 0 for exactly this cycle.
    - Route ramload to the granted core's iload or dload; all other load lanes are 0.
    - Next state is DONE.
  - FREE, BUSY and ERROR all count as "not done": increment the counter and stay in XFER.
  - When the counter reaches TIMEOUT-1 without ACCESS: pulse timeout_err, go to DONE; no wait bit drops.
- DONE:
  - Single turnaround cycle; RAM enables are 0.
  - Set rr_ptr = gnt_cpu+1 modulo CPUS, go to IDLE.
  - This guarantees a re-request from the same core is never back-to-back ahead of a pending peer.
- Minimum latency from request to wait low: 2 cycles (IDLE sample, then XFER with ACCESS). Back-to-back throughput is one transaction per 3 cycles.
- Wait bits not belonging to the active granted source are always 1.
- Counter width is clog2(TIMEOUT)+1; the counter never wraps.

Test Plan:
- Reset, then a single request: RST high for 2 cycles, then core0 iREN=1, iaddr=0x100, ramstate=ACCESS on the 2nd cycle → ramREN=1 and ramaddr=0x100 in XFER; iwait[0]=0 for one cycle with iload[0]=ramload=0xDEADBEEF; gnt_cpu=0.
- Intra-core priority: core1 asserts iREN, dREN, dWEN together with daddr=0x200, dstore=0x55 → ramWEN=1, ramREN=0, ramaddr=0x200, ramstore=0x55; dwait[1] low on ACCESS; iwait[1] stays 1.
- Fairness: both cores hold dREN continuously, ACCESS after 1 BUSY cycle each time → grants alternate 0,1,0,1; each transaction takes 4 cycles; neither core starves.
- Timeout: TIMEOUT=8, core0 dREN, ramstate held at BUSY → timeout_err pulses exactly 7 cycles after entering XFER; dwait[0] never 0; rr_ptr advances to 1.
- Request withdrawal: core1 dREN granted, drops dREN while BUSY → next cycle IDLE, ramREN=0, no wait pulse; rr_ptr unchanged, so core1 wins again on re-request.
- Reset mid-transaction: RST asserted in XFER with ramstate=ACCESS in the same cycle → all wait bits 1, ramREN=0, FSM in IDLE on the next edge.
